// File: rtl/regfile_writeback_pkg.sv
// Shared widths, default queue depth and the queued write-back entry type
// used by the write-back queue, its bypass matcher and the bus interface.
package regfile_writeback_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, register-file write/read ports and bypassed operands
// of the write-back unit; slave is the write-back unit, master its surroundings.
interface regfile_writeback_if #(
  parameter int DEPTH = regfile_writeback_pkg::WB_DEPTH
) ();
  import regfile_writeback_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;

  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  logic [DEPTH-1:0]  pending;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output RegWrite, WriteReg, WriteData,
    input  rs1, rs2, rf_data1, rf_data2,
    output op1, op2,
    output pending
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  RegWrite, WriteReg, WriteData,
    output rs1, rs2, rf_data1, rf_data2,
    input  op1, op2,
    input  pending
  );

endinterface

// File: rtl/regfile_writeback_wb_bypass_match.sv
// Finds the youngest valid queue entry whose destination matches one operand
// index; purely combinational.
module wb_bypass_match
  import regfile_writeback_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = DEPTH
) (
  input  wb_entry_t         entries_i [DEPTH],
  input  logic [PTR_W-1:0]  head_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [ADDR_W-1:0] rs_i,
  output logic [DATA_W-1:0] data_o,
  output logic              hit_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    data_o = '0;
    hit_o  = 1'b0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if ((CNT_W'(i) < count_i) && (entries_i[idx].rd == rs_i)) begin
        data_o = entries_i[idx].data;
        hit_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// In-order write-back queue merging ALU and load results into the single
// register-file write port, with youngest-pending bypass on both operand reads.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  regfile_writeback_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = DEPTH;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        entries_q [DEPTH];

  logic             popEn;
  logic [CNT_W:0]   freeSlots;
  logic             aluReady;
  logic             memReady;
  logic             aluPush;
  logic             memPush;
  logic [PTR_W-1:0] memSlot;

  logic [DATA_W-1:0] match1Data, match2Data;
  logic              match1Hit, match2Hit;

  // The head drains every cycle the queue is non-empty, so its slot is free now.
  always_comb begin
    popEn     = (count_q != '0);
    freeSlots = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(popEn);
    aluReady  = (freeSlots >= (CNT_W+1)'(1));
    memReady  = (freeSlots >= (CNT_W+1)'(2)) ||
                ((freeSlots >= (CNT_W+1)'(1)) && !bus.alu_valid);
    aluPush   = bus.alu_valid && aluReady && (bus.alu_rd != '0);
    memPush   = bus.mem_valid && memReady && (bus.mem_rd != '0);
    memSlot   = tail_q + PTR_W'(aluPush);
    head_d    = head_q + PTR_W'(popEn);
    tail_d    = tail_q + PTR_W'(aluPush) + PTR_W'(memPush);
    count_d   = count_q - CNT_W'(popEn) + CNT_W'(aluPush) + CNT_W'(memPush);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: the occupancy count alone decides validity.
  always_ff @(posedge clk) begin
    if (aluPush) begin
      entries_q[tail_q] <= '{rd: bus.alu_rd, data: bus.alu_data};
    end
    if (memPush) begin
      entries_q[memSlot] <= '{rd: bus.mem_rd, data: bus.mem_data};
    end
  end

  wb_bypass_match #(.DEPTH(DEPTH)) u_match1 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .rs_i      (bus.rs1),
    .data_o    (match1Data),
    .hit_o     (match1Hit)
  );

  wb_bypass_match #(.DEPTH(DEPTH)) u_match2 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .rs_i      (bus.rs2),
    .data_o    (match2Data),
    .hit_o     (match2Hit)
  );

  assign bus.alu_ready = aluReady;
  assign bus.mem_ready = memReady;
  assign bus.RegWrite  = popEn;
  assign bus.WriteReg  = popEn ? entries_q[head_q].rd   : '0;
  assign bus.WriteData = popEn ? entries_q[head_q].data : '0;
  assign bus.pending   = count_q;
  assign bus.op1       = match1Hit ? match1Data : bus.rf_data1;
  assign bus.op2       = match2Hit ? match2Data : bus.rf_data2;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised and directed bench for regfile_writeback against a queue-based
// model of pending writes plus an architectural register-file model.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int DEPTH = WB_DEPTH;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_writeback_if bus ();

  regfile_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } pendEntry;

  pendEntry    modelQueue[$];
  logic [31:0] rfModel    [32];
  logic [31:0] latestVal  [32];

  int assertCount = 0;
  int failCount   = 0;

  logic        lastRegWrite, lastAluReady, lastMemReady;
  logic [4:0]  lastWriteReg;
  logic [31:0] lastWriteData, lastOp1, lastOp2;
  logic [3:0]  lastPending;
  bit          sawMemStall;
  int          regWriteRun;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive, check all outputs against the model, then advance the model.
  task automatic applyStimulus(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                               input bit mv, input logic [4:0] mr, input logic [31:0] md,
                               input logic [4:0] r1, input logic [4:0] r2);
    int          n;
    int          freeCnt;
    bit          expAR, expMR, aluTake, memTake;
    logic [4:0]  expWR;
    logic [31:0] expWD;
    @(negedge clk);
    bus.alu_valid = av;  bus.alu_rd = ar;  bus.alu_data = ad;
    bus.mem_valid = mv;  bus.mem_rd = mr;  bus.mem_data = md;
    bus.rs1 = r1;        bus.rs2 = r2;
    bus.rf_data1 = rfModel[r1];
    bus.rf_data2 = rfModel[r2];
    #1;
    n       = modelQueue.size();
    freeCnt = DEPTH - n + ((n != 0) ? 1 : 0);
    expAR   = (freeCnt >= 1);
    expMR   = (freeCnt >= 2) || ((freeCnt >= 1) && !av);
    expWR   = (n != 0) ? modelQueue[0].rd   : 5'd0;
    expWD   = (n != 0) ? modelQueue[0].data : 32'd0;
    lastRegWrite  = bus.RegWrite;   lastWriteReg = bus.WriteReg;
    lastWriteData = bus.WriteData;  lastAluReady = bus.alu_ready;
    lastMemReady  = bus.mem_ready;  lastPending  = bus.pending;
    lastOp1       = bus.op1;        lastOp2      = bus.op2;
    if (bus.mem_ready === 1'b0) sawMemStall = 1'b1;
    checkOutput("RegWrite",  32'(bus.RegWrite),  32'(n != 0));
    checkOutput("WriteReg",  32'(bus.WriteReg),  32'(expWR));
    checkOutput("WriteData", bus.WriteData,      expWD);
    checkOutput("alu_ready", 32'(bus.alu_ready), 32'(expAR));
    checkOutput("mem_ready", 32'(bus.mem_ready), 32'(expMR));
    checkOutput("pending",   32'(bus.pending),   32'(n));
    checkOutput("op1",       bus.op1,            latestVal[r1]);
    checkOutput("op2",       bus.op2,            latestVal[r2]);
    aluTake = av && expAR;
    memTake = mv && expMR;
    @(posedge clk);
    if (n != 0) begin
      rfModel[modelQueue[0].rd] = modelQueue[0].data;
      void'(modelQueue.pop_front());
    end
    if (aluTake && ar != 5'd0) begin
      modelQueue.push_back('{rd: ar, data: ad});
      latestVal[ar] = ad;
    end
    if (memTake && mr != 5'd0) begin
      modelQueue.push_back('{rd: mr, data: md});
      latestVal[mr] = md;
    end
  endtask

  task automatic idleCycle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear before any edge.
  task automatic applyReset(input logic [4:0] r1);
    @(negedge clk);
    #2;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.rs1 = r1;
    bus.rf_data1 = rfModel[r1];
    reset = 1'b0;
    #1;
    checkOutput("rst_pending",   32'(bus.pending),   32'd0);
    checkOutput("rst_RegWrite",  32'(bus.RegWrite),  32'd0);
    checkOutput("rst_WriteReg",  32'(bus.WriteReg),  32'd0);
    checkOutput("rst_WriteData", bus.WriteData,      32'd0);
    checkOutput("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    checkOutput("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    checkOutput("rst_op1",       bus.op1,            rfModel[r1]);
    modelQueue.delete();
    latestVal = rfModel;
    @(posedge clk);
    #1;
    checkOutput("rst_hold_RegWrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rf_data1 = '0; bus.rf_data2 = '0;
    for (int i = 0; i < 32; i++) rfModel[i] = $urandom;
    rfModel[0] = 32'd0;
    latestVal = rfModel;
    applyReset(5'd9);

    $display("[TB] single ALU write");
    applyStimulus(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idleCycle(5'd5, 5'd0);
    checkOutput("single_RegWrite",  32'(lastRegWrite), 32'd1);
    checkOutput("single_WriteReg",  32'(lastWriteReg), 32'd5);
    checkOutput("single_WriteData", lastWriteData,     32'h0000_00AA);
    checkOutput("single_op1",       lastOp1,           32'h0000_00AA);
    idleCycle(5'd0, 5'd0);
    checkOutput("single_done",      32'(lastRegWrite), 32'd0);

    $display("[TB] same-cycle ALU and load to one register");
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd0);
    idleCycle(5'd3, 5'd0);
    checkOutput("pair_first",   lastWriteData,    32'h11);
    checkOutput("pair_op1",     lastOp1,          32'h22);
    checkOutput("pair_pending", 32'(lastPending), 32'd2);
    idleCycle(5'd3, 5'd0);
    checkOutput("pair_second",  lastWriteData,    32'h22);
    idleCycle(5'd3, 5'd0);
    checkOutput("pair_drained", 32'(lastRegWrite), 32'd0);
    checkOutput("pair_rf_op1",  lastOp1,           32'h22);

    $display("[TB] load to x0");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    checkOutput("x0_mem_ready", 32'(lastMemReady), 32'd1);
    idleCycle(5'd0, 5'd0);
    checkOutput("x0_RegWrite",  32'(lastRegWrite), 32'd0);
    checkOutput("x0_pending",   32'(lastPending),  32'd0);

    $display("[TB] rs2 bypass");
    rfModel[7]   = 32'h1234_5678;
    latestVal[7] = 32'h1234_5678;
    idleCycle(5'd0, 5'd7);
    checkOutput("byp_nomatch", lastOp2, 32'h1234_5678);
    applyStimulus(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd0, 5'd7);
    checkOutput("byp_no_fwd_inputs", lastOp2, 32'h1234_5678);
    idleCycle(5'd0, 5'd7);
    checkOutput("byp_youngest", lastOp2, 32'h2);
    idleCycle(5'd0, 5'd7);
    idleCycle(5'd0, 5'd7);

    $display("[TB] fill with both producers");
    sawMemStall = 1'b0;
    regWriteRun = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 5'(k + 1), $urandom, 1'b1, 5'(k + 10), $urandom,
                    5'(k + 1), 5'(k + 10));
      if (k > 0 && lastRegWrite === 1'b1) regWriteRun++;
    end
    checkOutput("fill_mem_stall", 32'(sawMemStall), 32'd1);
    checkOutput("fill_stream",    32'(regWriteRun), 32'd7);
    for (int k = 0; k < DEPTH + 1; k++) idleCycle(5'(k + 1), 5'(k + 10));

    $display("[TB] reset with entries queued");
    applyStimulus(1'b1, 5'd1, $urandom, 1'b1, 5'd2, $urandom, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd4, $urandom, 1'b1, 5'd6, $urandom, 5'd0, 5'd0);
    checkOutput("pre_reset_pending", 32'(modelQueue.size()), 32'd3);
    applyReset(5'd4);
    idleCycle(5'd1, 5'd6);
    idleCycle(5'd2, 5'd4);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (c == 200) applyReset(5'($urandom_range(0, 7)));
    end
    for (int k = 0; k < DEPTH + 1; k++) idleCycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
